wrr_bus_arbiter: RTL and testbench

WRR_BUS_ARBITER -- requirements
Module: wrr_bus_arbiter

---
 rtl/bus_arb_pkg.sv | 7 +
 rtl/wrr_grant_select.sv | 32 +++
 rtl/wrr_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_wrr_bus_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and constants for the weighted round-robin bus arbiter
package bus_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam int CLIENT_ID_W = 2;
    localparam int NUM_CLIENTS = 4;
    localparam logic [255:0] TIMEOUT_DATA = '1;
endpackage

// File: rtl/wrr_grant_select.sv
// wrr_grant_select: picks the next client, re-granting the owner while it has weight credit left
module wrr_grant_select
    import bus_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0]   rq_i,
    input  logic [CLIENT_ID_W-1:0]   owner_i,
    input  logic [3:0]               credit_i,
    input  logic [4*NUM_CLIENTS-1:0] weights_i,
    output logic [CLIENT_ID_W-1:0]   winner_o,
    output logic                     regrant_o
);
    logic [3:0] wt;
    logic [CLIENT_ID_W-1:0] cand;
    logic found;
    always_comb begin
        wt = weights_i[{owner_i, 2'b00} +: 4];
        // zero credit means no current owner; a zero weight then behaves as one
        regrant_o = rq_i[owner_i] && credit_i != 4'd0 && credit_i < wt;
        winner_o = owner_i;
        cand = '0;
        found = 1'b0;
        if (!regrant_o) begin
            for (int i = 1; i <= NUM_CLIENTS; i++) begin
                cand = owner_i + CLIENT_ID_W'(i);
                if (!found && rq_i[cand]) begin
                    winner_o = cand;
                    found = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/wrr_bus_arbiter.sv
// wrr_bus_arbiter: weighted round-robin arbiter forwarding four client requests to one server
module wrr_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int         DATA_WIDTH      = 8,
    parameter int         ADDR_WIDTH      = 4,
    parameter logic [3:0] CLIENT_1_WEIGHT = 4'd1,
    parameter logic [3:0] CLIENT_2_WEIGHT = 4'd1,
    parameter logic [3:0] CLIENT_3_WEIGHT = 4'd1,
    parameter logic [3:0] CLIENT_4_WEIGHT = 4'd1,
    parameter int         TIMEOUT         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] client_1_address,
    input  logic                  client_1_rq,
    input  logic                  client_1_wr_ni,
    input  logic [DATA_WIDTH-1:0] client_1_dataW,
    output logic                  client_1_ack,
    output logic [DATA_WIDTH-1:0] client_1_dataR,
    input  logic [ADDR_WIDTH-1:0] client_2_address,
    input  logic                  client_2_rq,
    input  logic                  client_2_wr_ni,
    input  logic [DATA_WIDTH-1:0] client_2_dataW,
    output logic                  client_2_ack,
    output logic [DATA_WIDTH-1:0] client_2_dataR,
    input  logic [ADDR_WIDTH-1:0] client_3_address,
    input  logic                  client_3_rq,
    input  logic                  client_3_wr_ni,
    input  logic [DATA_WIDTH-1:0] client_3_dataW,
    output logic                  client_3_ack,
    output logic [DATA_WIDTH-1:0] client_3_dataR,
    input  logic [ADDR_WIDTH-1:0] client_4_address,
    input  logic                  client_4_rq,
    input  logic                  client_4_wr_ni,
    input  logic [DATA_WIDTH-1:0] client_4_dataW,
    output logic                  client_4_ack,
    output logic [DATA_WIDTH-1:0] client_4_dataR,
    output logic [ADDR_WIDTH-1:0] server_address,
    output logic                  server_wr_ni,
    output logic [DATA_WIDTH-1:0] server_dataW,
    output logic                  server_rq,
    input  logic                  server_ack,
    input  logic [DATA_WIDTH-1:0] server_dataR,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  timeout_err
);
    logic [NUM_CLIENTS-1:0] c_rq, c_wr;
    logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] c_addr;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] c_dw;
    logic [CLIENT_ID_W-1:0] winner;
    logic regrant;
    state_t state_q, state_d;
    logic [CLIENT_ID_W-1:0] owner_q, owner_d;
    logic [3:0] credit_q, credit_d;
    logic [7:0] timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic wr_q, wr_d, srq_q, srq_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] dw_q, dw_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] data_q, data_d;

    assign c_rq   = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
    assign c_wr   = {client_4_wr_ni, client_3_wr_ni, client_2_wr_ni, client_1_wr_ni};
    assign c_addr = {client_4_address, client_3_address, client_2_address, client_1_address};
    assign c_dw   = {client_4_dataW, client_3_dataW, client_2_dataW, client_1_dataW};

    wrr_grant_select u_sel (
        .rq_i     (c_rq),
        .owner_i  (owner_q),
        .credit_i (credit_q),
        .weights_i({CLIENT_4_WEIGHT, CLIENT_3_WEIGHT, CLIENT_2_WEIGHT, CLIENT_1_WEIGHT}),
        .winner_o (winner),
        .regrant_o(regrant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        credit_d = credit_q;
        timer_d = timer_q;
        addr_d = addr_q;
        wr_d = wr_q;
        dw_d = dw_q;
        srq_d = srq_q;
        err_d = 1'b0;
        ack_d = '0;
        data_d = data_q;
        if (state_q == ST_IDLE) begin
            if (|c_rq) begin
                state_d = ST_WAIT;
                owner_d = winner;
                credit_d = regrant ? credit_q + 4'd1 : 4'd1;
                timer_d = '0;
                addr_d = c_addr[winner];
                wr_d = c_wr[winner];
                dw_d = c_dw[winner];
                srq_d = 1'b1;
            end
        end else if (state_q == ST_WAIT) begin
            if (server_ack || timer_q == 8'(TIMEOUT - 1)) begin
                state_d = ST_RESP;
                srq_d = 1'b0;
                err_d = !server_ack;
                ack_d[owner_q] = 1'b1;
                data_d[owner_q] = server_ack ? server_dataR : TIMEOUT_DATA[DATA_WIDTH-1:0];
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= CLIENT_ID_W'(NUM_CLIENTS - 1);
            credit_q <= '0;
            timer_q <= '0;
            addr_q <= '0;
            wr_q <= 1'b0;
            dw_q <= '0;
            srq_q <= 1'b0;
            err_q <= 1'b0;
            ack_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            credit_q <= credit_d;
            timer_q <= timer_d;
            addr_q <= addr_d;
            wr_q <= wr_d;
            dw_q <= dw_d;
            srq_q <= srq_d;
            err_q <= err_d;
            ack_q <= ack_d;
            data_q <= data_d;
        end
    end

    assign server_address = addr_q;
    assign server_wr_ni = wr_q;
    assign server_dataW = dw_q;
    assign server_rq = srq_q;
    assign grant_id = owner_q;
    assign busy = state_q != ST_IDLE;
    assign timeout_err = err_q;
    assign {client_4_ack, client_3_ack, client_2_ack, client_1_ack} = ack_q;
    assign client_1_dataR = data_q[0];
    assign client_2_dataR = data_q[1];
    assign client_3_dataR = data_q[2];
    assign client_4_dataR = data_q[3];
endmodule

// File: tb/tb_wrr_bus_arbiter.sv
// tb_wrr_bus_arbiter: directed checks of grant order, latency, timeout and reset abort
module tb_wrr_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] rq = '0, wr = '0, ack;
    logic [3:0] addr [4];
    logic [7:0] dw [4], dr [4];
    logic [3:0] server_address;
    logic server_wr_ni, server_rq, server_ack, busy, timeout_err;
    logic [7:0] server_dataW, server_dataR;
    logic [1:0] grant_id;
    logic [7:0] ram [16];
    int srv_dly = 0;
    int cnt = 0;
    logic srv_en = 1'b1, stray = 1'b0;
    int passed = 0, total = 0;
    int lat, srq_n;
    logic busy_low, err_seen;
    logic [3:0] ack_seen;
    int order [8] = '{0, 0, 1, 2, 3, 0, 0, 1};

    wrr_bus_arbiter #(.CLIENT_1_WEIGHT(4'd2)) dut (
        .clk(clk), .reset(reset),
        .client_1_address(addr[0]), .client_1_rq(rq[0]), .client_1_wr_ni(wr[0]), .client_1_dataW(dw[0]),
        .client_1_ack(ack[0]), .client_1_dataR(dr[0]),
        .client_2_address(addr[1]), .client_2_rq(rq[1]), .client_2_wr_ni(wr[1]), .client_2_dataW(dw[1]),
        .client_2_ack(ack[1]), .client_2_dataR(dr[1]),
        .client_3_address(addr[2]), .client_3_rq(rq[2]), .client_3_wr_ni(wr[2]), .client_3_dataW(dw[2]),
        .client_3_ack(ack[2]), .client_3_dataR(dr[2]),
        .client_4_address(addr[3]), .client_4_rq(rq[3]), .client_4_wr_ni(wr[3]), .client_4_dataW(dw[3]),
        .client_4_ack(ack[3]), .client_4_dataR(dr[3]),
        .server_address(server_address), .server_wr_ni(server_wr_ni), .server_dataW(server_dataW),
        .server_rq(server_rq), .server_ack(server_ack), .server_dataR(server_dataR),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // server acks once its request has been high for srv_dly cycles
    assign server_ack = stray || (srv_en && server_rq && cnt >= srv_dly);
    assign server_dataR = ram[server_address];
    always @(posedge clk) begin
        cnt <= server_rq ? cnt + 1 : 0;
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h10 + 8'(i);
        end else if (server_ack && server_rq && server_wr_ni) begin
            ram[server_address] <= server_dataW;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int k, input logic w, input logic [3:0] a, input logic [7:0] d);
        rq[k] = 1'b1; wr[k] = w; addr[k] = a; dw[k] = d;
        lat = 0; srq_n = 0; busy_low = 1'b0;
        do begin
            tick();
            lat++;
            if (server_rq) srq_n++;
            if (!busy) busy_low = 1'b1;
        end while (!ack[k] && lat < 60);
        err_seen = timeout_err;
        ack_seen = ack;
        rq[k] = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0;
            dw[i] = '0;
        end
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_srq", server_rq, 0);
        chk("rst_gid", grant_id, 3);
        chk("rst_ack", ack, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_saddr", server_address, 0);
        chk("rst_dr", dr[1], 0);
        reset = 1'b0;
        tick();
        rq[1] = 1'b1; wr[1] = 1'b1; addr[1] = 4'd5; dw[1] = 8'h3C;
        tick();
        chk("w2_srq", server_rq, 1);
        chk("w2_gid", grant_id, 1);
        chk("w2_addr", server_address, 5);
        chk("w2_wr", server_wr_ni, 1);
        chk("w2_dw", server_dataW, 8'h3C);
        chk("w2_noack", ack, 0);
        tick();
        chk("w2_ack", ack, 4'b0010);
        chk("w2_ram", ram[5], 8'h3C);
        chk("w2_dr", dr[1], 8'h15);
        chk("w2_busy", busy, 1);
        rq[1] = 1'b0;
        tick();
        chk("w2_idle", {busy, server_rq, ack}, 0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_ack", ack, 0);
        xact(2, 1'b1, 4'd9, 8'hA5);
        chk("w3_lat", lat, 2);
        chk("w3_srq", srq_n, 1);
        chk("w3_err", err_seen, 0);
        chk("w3_ram", ram[9], 8'hA5);
        srv_dly = 3;
        xact(2, 1'b0, 4'd9, 8'h00);
        srv_dly = 0;
        chk("r3_lat", lat, 5);
        chk("r3_dr", dr[2], 8'hA5);
        chk("r3_busy", busy_low, 0);
        chk("r3_ack", ack_seen, 4'b0100);
        srv_en = 1'b0;
        xact(0, 1'b0, 4'd2, 8'h00);
        srv_en = 1'b1;
        chk("to_lat", lat, 17);
        chk("to_srq", srq_n, 16);
        chk("to_err", err_seen, 1);
        chk("to_dr", dr[0], 8'hFF);
        chk("to_pulse", timeout_err, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr = '0;
        rq = 4'hF;
        for (int g = 0; g < 8; g++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (ack == 4'd0 && n < 10);
            chk($sformatf("wrr_%0d", g), ack, 32'(1) << order[g]);
        end
        rq = '0;
        tick();
        tick();
        srv_en = 1'b0;
        rq[1] = 1'b1; wr[1] = 1'b0; addr[1] = 4'd3;
        tick();
        tick();
        chk("rw_wait", server_rq, 1);
        reset = 1'b1;
        rq[1] = 1'b0;
        tick();
        reset = 1'b0;
        chk("rw_srq", server_rq, 0);
        chk("rw_ack", ack, 0);
        chk("rw_gid", grant_id, 3);
        chk("rw_busy", busy, 0);
        srv_en = 1'b1;
        xact(3, 1'b0, 4'd4, 8'h00);
        chk("c4_lat", lat, 2);
        chk("c4_ack", ack_seen, 4'b1000);
        chk("c4_gid", grant_id, 3);
        chk("c4_dr", dr[3], 8'h14);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end
endmodule
